// File: rtl/charge_station_ctrl.sv
// Multi-outlet charging controller: one shared keypad sets up sessions that
// count down concurrently, one per outlet, driving relays and the display.
module charge_station_ctrl #(
   parameter int CHANNELS  = 4,
   parameter int CHAN_W    = 2,
   parameter int W         = 8,
   parameter int MAX_MONEY = 20,
   parameter int RATE      = 2,
   parameter int SECOND    = 25000,
   parameter int PAUSE     = 250000
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  startSet,
   input  logic [4:0]            num,
   input  logic                  start,
   input  logic                  clear,
   input  logic                  enter,
   input  logic [CHAN_W-1:0]     chan_sel,
   output logic [W-1:0]          money,
   output logic [W-1:0]          restime,
   output logic [CHAN_W-1:0]     edit_chan,
   output logic [CHANNELS-1:0]   active,
   output logic [CHANNELS-1:0]   done,
   output logic                  reject,
   output logic [CHANNELS*W-1:0] chan_time
);
   localparam logic [W-1:0] BLANK = '1;
   localparam int PS_W = (SECOND > 1) ? $clog2(SECOND) : 1;
   localparam int IC_W = (PAUSE > 1) ? $clog2(PAUSE) : 1;

   typedef enum logic {S_IDLE, S_EDIT} state_t;
   typedef enum logic [2:0] {K_NONE, K_DIGIT, K_START, K_CLEAR, K_ENTER} key_t;

   state_t              r_state, w_state_nxt;
   key_t                w_key;
   logic                r_last_set;
   logic                w_key_evt;
   logic [PS_W-1:0]     r_presc;
   logic                w_tick;
   logic [IC_W-1:0]     r_idle_cnt;
   logic                w_timeout;
   logic                w_commit;
   logic                w_chan_free;
   logic [W-1:0]        r_money, r_restime;
   logic [W-1:0]        w_money_nxt, w_restime_nxt;
   logic [CHAN_W-1:0]   r_edit_chan, w_edit_chan_nxt;
   logic                r_reject, w_reject_nxt;
   logic [CHANNELS-1:0] r_active, r_done;
   logic [W-1:0]        r_time [CHANNELS];
   logic [9:0]          w_acc, w_mod;
   logic [W-1:0]        w_money_dig;

   assign w_key_evt = startSet & ~r_last_set;
   assign w_tick    = (r_presc == PS_W'(SECOND - 1));

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      w_key = K_NONE;
      if (w_key_evt) begin
         if (enter)              w_key = K_ENTER;
         else if (clear)         w_key = K_CLEAR;
         else if (start)         w_key = K_START;
         else if (num < 5'd10)   w_key = K_DIGIT;
      end
   end

   // Out-of-range selects never match an outlet, so they read as busy.
   always_comb begin
      w_chan_free = 1'b0;
      for (int i = 0; i < CHANNELS; i++)
         if (chan_sel == CHAN_W'(i)) w_chan_free = ~r_active[i];
   end

   assign w_commit  = (r_state == S_EDIT) && (w_key == K_ENTER) && (r_money != '0);
   assign w_timeout = (r_state == S_EDIT) && !w_key_evt && (r_idle_cnt == IC_W'(PAUSE - 1));

   assign w_acc       = 10'(r_money) * 10'd10 + 10'(num);
   assign w_mod       = w_acc % 10'd100;
   assign w_money_dig = (w_mod > 10'(MAX_MONEY)) ? W'(MAX_MONEY) : W'(w_mod);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_key == K_START && w_chan_free) w_state_nxt = S_EDIT;
         S_EDIT: if (w_commit || w_timeout)          w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_money_nxt     = r_money;
      w_restime_nxt   = r_restime;
      w_edit_chan_nxt = r_edit_chan;
      w_reject_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_money_nxt   = BLANK;
            w_restime_nxt = BLANK;
            if (w_key == K_START) begin
               if (w_chan_free) begin
                  w_money_nxt     = '0;
                  w_restime_nxt   = '0;
                  w_edit_chan_nxt = chan_sel;
               end else begin
                  w_reject_nxt = 1'b1;
               end
            end
         end
         S_EDIT: begin
            if (w_commit || w_timeout) begin
               w_money_nxt   = BLANK;
               w_restime_nxt = BLANK;
            end else if (w_key == K_DIGIT) begin
               w_money_nxt   = w_money_dig;
               w_restime_nxt = W'(32'(w_money_dig) * RATE);
            end else if (w_key == K_CLEAR) begin
               w_money_nxt   = '0;
               w_restime_nxt = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_last_set  <= 1'b0;
         r_presc     <= '0;
         r_idle_cnt  <= '0;
         r_money     <= BLANK;
         r_restime   <= BLANK;
         r_edit_chan <= '0;
         r_reject    <= 1'b0;
      end else begin
         r_last_set  <= startSet;
         r_presc     <= w_tick ? '0 : r_presc + PS_W'(1);
         r_idle_cnt  <= (r_state == S_EDIT && !w_key_evt) ? r_idle_cnt + IC_W'(1) : '0;
         r_money     <= w_money_nxt;
         r_restime   <= w_restime_nxt;
         r_edit_chan <= w_edit_chan_nxt;
         r_reject    <= w_reject_nxt;
      end
   end

   // NOTE: the per-outlet time array is reset explicitly because reset must cancel every session.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < CHANNELS; i++) r_time[i] <= '0;
         r_active <= '0;
         r_done   <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_done[i] <= 1'b0;
            if (w_commit && (r_edit_chan == CHAN_W'(i))) begin
               r_time[i]   <= r_restime;
               r_active[i] <= 1'b1;
            end else if (w_tick && r_active[i] && (r_time[i] != '0)) begin
               r_time[i] <= r_time[i] - W'(1);
               if (r_time[i] == W'(1)) begin
                  r_active[i] <= 1'b0;
                  r_done[i]   <= 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      chan_time = '0;
      for (int i = 0; i < CHANNELS; i++) chan_time[i*W +: W] = r_time[i];
   end

   assign money     = r_money;
   assign restime   = r_restime;
   assign edit_chan = r_edit_chan;
   assign active    = r_active;
   assign done      = r_done;
   assign reject    = r_reject;

endmodule

// File: tb/tb_charge_station_ctrl.sv
// Scoreboard bench for charge_station_ctrl with a fast prescaler and short timeout.
module tb_charge_station_ctrl;
   localparam int CH = 4;
   localparam int CW = 3;
   localparam int W  = 8;

   logic          CLK;
   logic          RST_N;
   logic          startSet;
   logic [4:0]    num;
   logic          start, clear, enter;
   logic [CW-1:0] chan_sel;
   logic [W-1:0]  money, restime;
   logic [CW-1:0] edit_chan;
   logic [CH-1:0] active, done;
   logic          reject;
   logic [CH*W-1:0] chan_time;

   charge_station_ctrl #(
      .CHANNELS(CH), .CHAN_W(CW), .W(W), .MAX_MONEY(20), .RATE(2), .SECOND(4), .PAUSE(20)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .startSet(startSet), .num(num), .start(start),
      .clear(clear), .enter(enter), .chan_sel(chan_sel), .money(money),
      .restime(restime), .edit_chan(edit_chan), .active(active), .done(done),
      .reject(reject), .chan_time(chan_time)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Index of the next rising edge since reset release; tick edges are those with index mod 4 == 3.
   int edge_n;
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   typedef struct packed {
      logic [7:0] money;
      logic [7:0] restime;
      logic       rej;
   } exp_t;

   exp_t          sb[$];
   int            n_vec;
   int            n_err;
   int            last_key_edge;
   int            n_c1;
   logic          obs_rej;
   logic [CH-1:0] obs_active;
   logic [CH*W-1:0] obs_time;

   function automatic int ticks_between(input int a, input int b);
      int c;
      c = 0;
      for (int n = a + 1; n <= b; n++) if (n % 4 == 3) c++;
      return c;
   endfunction

   task automatic press(input logic [4:0] k_num, input logic k_start, input logic k_clear,
                        input logic k_enter, input logic [CW-1:0] k_chan,
                        input logic [7:0] e_money, input logic [7:0] e_restime,
                        input logic e_rej, input string tag);
      exp_t e;
      e.money = e_money; e.restime = e_restime; e.rej = e_rej;
      sb.push_back(e);
      num = k_num; start = k_start; clear = k_clear; enter = k_enter; chan_sel = k_chan;
      startSet = 1'b1;
      last_key_edge = edge_n;
      @(negedge CLK);
      obs_rej = reject; obs_active = active; obs_time = chan_time;
      startSet = 1'b0; start = 1'b0; clear = 1'b0; enter = 1'b0; num = 5'd0;
      @(negedge CLK);
      e = sb.pop_front();
      n_vec++;
      if (money !== e.money) begin
         n_err++; $display("FAIL %s money: got %h expected %h", tag, money, e.money);
      end
      n_vec++;
      if (restime !== e.restime) begin
         n_err++; $display("FAIL %s restime: got %h expected %h", tag, restime, e.restime);
      end
      n_vec++;
      if (obs_rej !== e.rej) begin
         n_err++; $display("FAIL %s reject: got %b expected %b", tag, obs_rej, e.rej);
      end
      n_vec++;
      if (reject !== 1'b0) begin
         n_err++; $display("FAIL %s reject_width: got %b expected 0", tag, reject);
      end
   endtask

   task automatic key_start(input logic [CW-1:0] ch, input logic [7:0] em, input logic [7:0] er,
                            input logic erej, input string tag);
      press(5'd31, 1'b1, 1'b0, 1'b0, ch, em, er, erej, tag);
   endtask

   task automatic key_digit(input logic [4:0] d, input logic [7:0] em, input logic [7:0] er,
                            input string tag);
      press(d, 1'b0, 1'b0, 1'b0, '0, em, er, 1'b0, tag);
   endtask

   task automatic wait_blank(input int exp_edge, input string tag);
      int obs;
      obs = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (money === 8'hFF) begin
            obs = edge_n - 1;
            break;
         end
      end
      n_vec++;
      if (obs != exp_edge) begin
         n_err++; $display("FAIL %s timeout_edge: got %0d expected %0d", tag, obs, exp_edge);
      end
   endtask

   task automatic test_reset;
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      n_vec++; if (money !== 8'hFF)   begin n_err++; $display("FAIL reset money: got %h expected ff", money); end
      n_vec++; if (restime !== 8'hFF) begin n_err++; $display("FAIL reset restime: got %h expected ff", restime); end
      n_vec++; if (active !== '0)     begin n_err++; $display("FAIL reset active: got %b expected 0", active); end
      n_vec++; if (chan_time !== '0)  begin n_err++; $display("FAIL reset chan_time: got %h expected 0", chan_time); end
      n_vec++; if (done !== '0)       begin n_err++; $display("FAIL reset done: got %b expected 0", done); end
      n_vec++; if (edit_chan !== '0)  begin n_err++; $display("FAIL reset edit_chan: got %0d expected 0", edit_chan); end
   endtask

   task automatic test_session;
      key_start(3'd1, 8'h00, 8'h00, 1'b0, "start_ch1");
      n_vec++; if (edit_chan !== 3'd1) begin n_err++; $display("FAIL start_ch1 edit_chan: got %0d expected 1", edit_chan); end
      key_digit(5'd1, 8'h01, 8'h02, "digit_1");
      key_digit(5'd5, 8'h0F, 8'h1E, "digit_5");
      press(5'd0, 1'b0, 1'b0, 1'b1, '0, 8'hFF, 8'hFF, 1'b0, "commit_ch1");
      n_c1 = last_key_edge;
      n_vec++; if (obs_time[1*W +: W] !== 8'd30) begin n_err++; $display("FAIL commit_ch1 time: got %0d expected 30", obs_time[1*W +: W]); end
      n_vec++; if (obs_active !== 4'b0010) begin n_err++; $display("FAIL commit_ch1 active: got %b expected 0010", obs_active); end
   endtask

   task automatic test_reject;
      key_start(3'd1, 8'hFF, 8'hFF, 1'b1, "start_busy_ch1");
      key_start(3'd5, 8'hFF, 8'hFF, 1'b1, "start_ch5");
      key_digit(5'd3, 8'hFF, 8'hFF, "idle_digit");
   endtask

   task automatic test_clamp_timeout;
      int k2;
      key_start(3'd0, 8'h00, 8'h00, 1'b0, "start_ch0");
      key_digit(5'd3, 8'd3, 8'd6, "digit_3");
      key_digit(5'd7, 8'd20, 8'd40, "digit_7_clamp");
      key_digit(5'd4, 8'd4, 8'd8, "digit_4_wrap");
      press(5'd0, 1'b0, 1'b1, 1'b0, '0, 8'd0, 8'd0, 1'b0, "clear");
      press(5'd0, 1'b0, 1'b0, 1'b1, '0, 8'd0, 8'd0, 1'b0, "enter_zero");
      wait_blank(last_key_edge + 20, "timeout_plain");
      n_vec++; if (active[0] !== 1'b0) begin n_err++; $display("FAIL timeout active0: got %b expected 0", active[0]); end
      key_start(3'd0, 8'h00, 8'h00, 1'b0, "restart_ch0");
      k2 = last_key_edge;
      while (edge_n < k2 + 19) @(negedge CLK);
      press(5'd15, 1'b0, 1'b0, 1'b0, '0, 8'd0, 8'd0, 1'b0, "late_key");
      wait_blank(last_key_edge + 20, "timeout_deferred");
   endtask

   task automatic test_done;
      int t, cnt, obs;
      t = n_c1; cnt = 0;
      while (cnt < 30) begin
         t++;
         if (t % 4 == 3) cnt++;
      end
      obs = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK);
         if (done[1] === 1'b1) begin
            obs = edge_n - 1;
            break;
         end
      end
      n_vec++; if (obs != t) begin n_err++; $display("FAIL done1 edge: got %0d expected %0d", obs, t); end
      n_vec++; if (active !== 4'b0000) begin n_err++; $display("FAIL done1 active: got %b expected 0000", active); end
      n_vec++; if (chan_time[1*W +: W] !== 8'd0) begin n_err++; $display("FAIL done1 time: got %0d expected 0", chan_time[1*W +: W]); end
      @(negedge CLK);
      n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL done1 width: got %b expected 0000", done); end
   endtask

   task automatic test_multi_reset;
      int n_a;
      logic [7:0] exp1;
      key_start(3'd1, 8'h00, 8'h00, 1'b0, "m_start_ch1");
      key_digit(5'd1, 8'd1, 8'd2, "m_digit_1");
      key_digit(5'd5, 8'd15, 8'd30, "m_digit_5");
      press(5'd0, 1'b0, 1'b0, 1'b1, '0, 8'hFF, 8'hFF, 1'b0, "m_commit_ch1");
      n_a = last_key_edge;
      key_start(3'd2, 8'h00, 8'h00, 1'b0, "m_start_ch2");
      key_digit(5'd4, 8'd4, 8'd8, "m_digit_4");
      press(5'd0, 1'b0, 1'b0, 1'b1, '0, 8'hFF, 8'hFF, 1'b0, "m_commit_ch2");
      n_vec++; if (obs_time[2*W +: W] !== 8'd8) begin n_err++; $display("FAIL m_commit_ch2 time: got %0d expected 8", obs_time[2*W +: W]); end
      n_vec++; if (obs_active !== 4'b0110) begin n_err++; $display("FAIL m_commit_ch2 active: got %b expected 0110", obs_active); end
      exp1 = 8'(30 - ticks_between(n_a, edge_n - 1));
      n_vec++; if (chan_time[1*W +: W] !== exp1) begin n_err++; $display("FAIL m_ch1 counting: got %0d expected %0d", chan_time[1*W +: W], exp1); end
      key_start(3'd3, 8'h00, 8'h00, 1'b0, "m_start_ch3");
      num = 5'd1; startSet = 1'b1;
      repeat (3) @(negedge CLK);
      startSet = 1'b0;
      @(negedge CLK);
      n_vec++; if (money !== 8'd1)   begin n_err++; $display("FAIL hold money: got %0d expected 1", money); end
      n_vec++; if (restime !== 8'd2) begin n_err++; $display("FAIL hold restime: got %0d expected 2", restime); end
      #2 RST_N = 1'b0;
      #1;
      n_vec++; if (money !== 8'hFF)   begin n_err++; $display("FAIL midreset money: got %h expected ff", money); end
      n_vec++; if (restime !== 8'hFF) begin n_err++; $display("FAIL midreset restime: got %h expected ff", restime); end
      n_vec++; if (active !== '0)     begin n_err++; $display("FAIL midreset active: got %b expected 0", active); end
      n_vec++; if (chan_time !== '0)  begin n_err++; $display("FAIL midreset chan_time: got %h expected 0", chan_time); end
      n_vec++; if (edit_chan !== '0)  begin n_err++; $display("FAIL midreset edit_chan: got %0d expected 0", edit_chan); end
      startSet = 1'b1; start = 1'b1; chan_sel = 3'd2; num = 5'd31;
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      startSet = 1'b0; start = 1'b0;
      n_vec++; if (money !== 8'h00)    begin n_err++; $display("FAIL release_event money: got %h expected 00", money); end
      n_vec++; if (edit_chan !== 3'd2) begin n_err++; $display("FAIL release_event edit_chan: got %0d expected 2", edit_chan); end
   endtask

   initial begin
      n_vec = 0; n_err = 0; last_key_edge = 0; n_c1 = 0;
      RST_N = 1'b0; startSet = 1'b0; num = 5'd0;
      start = 1'b0; clear = 1'b0; enter = 1'b0; chan_sel = '0;
      test_reset();
      test_session();
      test_reject();
      test_clamp_timeout();
      test_done();
      test_multi_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
